cu_stage_sequencer: RTL and testbench

Control-unit stage sequencer: drives the four-phase fetch/decode/issue/commit cycle of the CU (the 2-bit result counter), owns the program counter and pulses the start strobes for memfetch, the instruction decoder and the ALU. Holds in place while the decoder or ALU is not ready, which also stalls JAL/JALR until the target is resolved. Applies branch/jump redirects and stops the core permanently on error, ECALL/EBREAK or an out-of-range PC. Sits inside the CU top level, between the memfetch unit, the instruction decoder and the ALU.

---
 rtl/cu_stage_sequencer_if.sv | 41 ++++
 rtl/cu_stage_sequencer.sv | 146 ++++++++++++++
 tb/tb_cu_stage_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cu_stage_sequencer_if.sv
// cu_stage_sequencer_if
//   Bundles the control signals between the CU stage sequencer and its neighbours
//   (memfetch unit, instruction decoder, ALU, branch/jump resolution).
//   master : the stage sequencer (drives PC, phase, start strobes, status)
//   slave  : the surrounding CU logic (drives run, ready/done, redirect, halt)
interface cu_stage_sequencer_if;
    // Sequencer inputs
    logic        run;
    logic        IDU_ready;
    logic        ALU_done;
    logic [31:0] pc_increment;
    logic        jump_valid;
    logic [31:0] jump_target;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        halt_req;
    // Sequencer outputs
    logic [31:0] Cu_PC;
    logic [1:0]  phase;
    logic        memfetch_start;
    logic        decode_start;
    logic        CU_ready;
    logic        last_branch_state;
    logic        halted;
    logic        pc_fault;
    logic [31:0] instr_count;

    modport master (
        input  run, IDU_ready, ALU_done, pc_increment, jump_valid, jump_target,
               branch_taken, branch_target, halt_req,
        output Cu_PC, phase, memfetch_start, decode_start, CU_ready,
               last_branch_state, halted, pc_fault, instr_count
    );

    modport slave (
        output run, IDU_ready, ALU_done, pc_increment, jump_valid, jump_target,
               branch_taken, branch_target, halt_req,
        input  Cu_PC, phase, memfetch_start, decode_start, CU_ready,
               last_branch_state, halted, pc_fault, instr_count
    );
endinterface

// File: rtl/cu_stage_sequencer.sv
// cu_stage_sequencer
//   Sequences the CU through FETCH/DECODE/ISSUE/COMMIT, owns the program counter,
//   pulses the memfetch/decoder/ALU start strobes, applies jump/branch redirects and
//   stops permanently on halt requests or an illegal next PC.
// Ports
//   soc_clk : system clock, rising edge
//   reset   : asynchronous, active-low reset
//   bus     : cu_stage_sequencer_if.master
//             in : run, IDU_ready, ALU_done, pc_increment, jump_valid/jump_target,
//                  branch_taken/branch_target, halt_req
//             out: Cu_PC, phase, memfetch_start, decode_start, CU_ready,
//                  last_branch_state, halted, pc_fault, instr_count (all registered)
module cu_stage_sequencer #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int unsigned PC_LIMIT = 512
) (
    input  logic                   soc_clk,
    input  logic                   reset,
    cu_stage_sequencer_if.master   bus
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StFetch  = 3'd1;
    localparam logic [2:0] StDecode = 3'd2;
    localparam logic [2:0] StIssue  = 3'd3;
    localparam logic [2:0] StCommit = 3'd4;
    localparam logic [2:0] StHalt   = 3'd5;

    localparam logic [31:0] PcLimit = 32'(PC_LIMIT);

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] cnt_q, cnt_d;
    logic        lbs_q, lbs_d;
    logic        fault_q, fault_d;
    logic [1:0]  phase_q, phase_d;
    logic        fetch_q, fetch_d;
    logic        dec_q, dec_d;
    logic        rdy_q, rdy_d;
    logic        halted_q, halted_d;

    logic [31:0] next_pc;
    logic        pc_bad;

    // Jump outranks branch; sequential path wraps at 32 bits.
    always_comb begin
        if (bus.jump_valid) begin
            next_pc = bus.jump_target;
        end else if (bus.branch_taken) begin
            next_pc = bus.branch_target;
        end else begin
            next_pc = pc_q + bus.pc_increment;
        end
        pc_bad = (next_pc >= PcLimit) || (next_pc[1:0] != 2'b00);
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        lbs_d   = lbs_q;
        fault_d = fault_q;

        case (state_q)
            StIdle:   if (bus.run) state_d = StFetch;
            StFetch:  state_d = StDecode;
            StDecode: if (bus.IDU_ready) state_d = StIssue;
            StIssue:  state_d = StCommit;
            StCommit: begin
                if (bus.ALU_done) begin
                    if (pc_bad) begin
                        state_d = StHalt;
                        fault_d = 1'b1;
                    end else begin
                        pc_d    = next_pc;
                        cnt_d   = cnt_q + 32'd1;
                        if (!bus.jump_valid) lbs_d = bus.branch_taken;
                        state_d = bus.run ? StFetch : StIdle;
                    end
                end
            end
            StHalt:   state_d = StHalt;
            default:  state_d = StIdle;
        endcase

        // An external halt overrides everything, including a retire in the same cycle.
        if (bus.halt_req && (state_q != StIdle)) begin
            state_d = StHalt;
            pc_d    = pc_q;
            cnt_d   = cnt_q;
            lbs_d   = lbs_q;
            fault_d = fault_q;
        end
    end

    // Outputs are decoded from the next state so they are registered yet aligned with it.
    always_comb begin
        case (state_d)
            StDecode: phase_d = 2'd1;
            StIssue:  phase_d = 2'd2;
            StCommit: phase_d = 2'd3;
            default:  phase_d = 2'd0;
        endcase
        fetch_d  = (state_d == StFetch);
        dec_d    = (state_d == StDecode) && (state_q != StDecode);
        rdy_d    = (state_d == StIssue);
        halted_d = (state_d == StHalt);
    end

    always_ff @(posedge soc_clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            pc_q     <= PC_RESET;
            cnt_q    <= 32'd0;
            lbs_q    <= 1'b0;
            fault_q  <= 1'b0;
            phase_q  <= 2'd0;
            fetch_q  <= 1'b0;
            dec_q    <= 1'b0;
            rdy_q    <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            lbs_q    <= lbs_d;
            fault_q  <= fault_d;
            phase_q  <= phase_d;
            fetch_q  <= fetch_d;
            dec_q    <= dec_d;
            rdy_q    <= rdy_d;
            halted_q <= halted_d;
        end
    end

    assign bus.Cu_PC             = pc_q;
    assign bus.phase             = phase_q;
    assign bus.memfetch_start    = fetch_q;
    assign bus.decode_start      = dec_q;
    assign bus.CU_ready          = rdy_q;
    assign bus.last_branch_state = lbs_q;
    assign bus.halted            = halted_q;
    assign bus.pc_fault          = fault_q;
    assign bus.instr_count       = cnt_q;

endmodule

// File: tb/tb_cu_stage_sequencer.sv
module tb_cu_stage_sequencer;

    logic soc_clk = 1'b0;
    logic reset;
    always #5 soc_clk = ~soc_clk;

    cu_stage_sequencer_if bus ();

    cu_stage_sequencer #(
        .PC_RESET(32'h0000_0000),
        .PC_LIMIT(512)
    ) dut (
        .soc_clk(soc_clk),
        .reset  (reset),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc;
    int n_ds = 0;
    int n_cr = 0;
    int fetch_q[$];

    // Instruction-level reference state
    logic [31:0] m_pc;
    logic [31:0] m_count;
    logic        m_lbs;

    always @(posedge soc_clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge soc_clk) begin
        if (bus.decode_start === 1'b1) n_ds <= n_ds + 1;
        if (bus.CU_ready === 1'b1)     n_cr <= n_cr + 1;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge soc_clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.IDU_ready     = 1'b0;
        bus.ALU_done      = 1'b0;
        bus.pc_increment  = 32'd4;
        bus.jump_valid    = 1'b0;
        bus.jump_target   = 32'd0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 32'd0;
        bus.halt_req      = 1'b0;
    endtask

    // Resets, checks reset values, releases with run=1 and returns with the DUT in FETCH.
    task automatic do_reset();
        @(negedge soc_clk);
        reset   = 1'b0;
        bus.run = 1'b0;
        clear_inputs();
        #1;
        chk("rst_pc",     bus.Cu_PC, 32'h0);
        chk("rst_phase",  32'(bus.phase), 32'd0);
        chk("rst_fetch",  32'(bus.memfetch_start), 32'd0);
        chk("rst_dec",    32'(bus.decode_start), 32'd0);
        chk("rst_rdy",    32'(bus.CU_ready), 32'd0);
        chk("rst_lbs",    32'(bus.last_branch_state), 32'd0);
        chk("rst_halted", 32'(bus.halted), 32'd0);
        chk("rst_fault",  32'(bus.pc_fault), 32'd0);
        chk("rst_count",  bus.instr_count, 32'd0);
        @(negedge soc_clk);
        reset   = 1'b1;
        bus.run = 1'b1;
        m_pc    = 32'h0;
        m_count = 32'd0;
        m_lbs   = 1'b0;
        step();
    endtask

    task automatic expect_halt();
        clear_inputs();
        @(negedge soc_clk);
        chk("halt_flag",    32'(bus.halted), 32'd1);
        chk("halt_phase",   32'(bus.phase), 32'd0);
        chk("halt_pc",      bus.Cu_PC, m_pc);
        chk("halt_count",   bus.instr_count, m_count);
        chk("halt_nofault", 32'(bus.pc_fault), 32'd0);
        chk("halt_nordy",   32'(bus.CU_ready), 32'd0);
        bus.run = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("halt_sticky",  32'(bus.halted), 32'd1);
            chk("halt_nofetch", 32'(bus.memfetch_start), 32'd0);
        end
    endtask

    // One instruction, entered and (unless stopped) left with the DUT in FETCH.
    // dw/aw: decoder/ALU wait cycles; halt_ph: 0 none, 1..4 = phase in which halt_req rises.
    task automatic do_instr(input int dw, input int aw, input bit jv, input logic [31:0] jt,
                            input bit bt, input logic [31:0] btg, input logic [31:0] inc,
                            input bit run_after, input int halt_ph, output bit stopped);
        logic [31:0] npc;
        stopped = 1'b0;
        bus.halt_req = (halt_ph == 1);
        @(negedge soc_clk);
        fetch_q.push_back(cyc);
        chk("fetch_strobe", 32'(bus.memfetch_start), 32'd1);
        chk("fetch_phase",  32'(bus.phase), 32'd0);
        chk("fetch_pc",     bus.Cu_PC, m_pc);
        chk("fetch_count",  bus.instr_count, m_count);
        chk("fetch_lbs",    32'(bus.last_branch_state), 32'(m_lbs));
        step();
        if (halt_ph == 1) begin expect_halt(); stopped = 1'b1; return; end

        bus.run = run_after;
        for (int k = 0; k <= dw; k++) begin
            bus.IDU_ready = (k == dw);
            bus.halt_req  = (halt_ph == 2);
            @(negedge soc_clk);
            chk("dec_phase",   32'(bus.phase), 32'd1);
            chk("dec_strobe",  32'(bus.decode_start), 32'(k == 0));
            chk("dec_nofetch", 32'(bus.memfetch_start), 32'd0);
            step();
            if (halt_ph == 2) begin expect_halt(); stopped = 1'b1; return; end
        end
        bus.IDU_ready = 1'b0;

        bus.halt_req = (halt_ph == 3);
        @(negedge soc_clk);
        chk("iss_ready", 32'(bus.CU_ready), 32'd1);
        chk("iss_phase", 32'(bus.phase), 32'd2);
        chk("iss_nodec", 32'(bus.decode_start), 32'd0);
        step();
        if (halt_ph == 3) begin expect_halt(); stopped = 1'b1; return; end

        bus.jump_valid    = jv;
        bus.jump_target   = jt;
        bus.branch_taken  = bt;
        bus.branch_target = btg;
        bus.pc_increment  = inc;
        for (int k = 0; k <= aw; k++) begin
            bus.ALU_done = (k == aw);
            bus.halt_req = (halt_ph == 4) && (k == aw);
            @(negedge soc_clk);
            chk("com_phase", 32'(bus.phase), 32'd3);
            chk("com_nordy", 32'(bus.CU_ready), 32'd0);
            step();
        end
        if (halt_ph == 4) begin expect_halt(); stopped = 1'b1; return; end
        clear_inputs();

        if (jv)      npc = jt;
        else if (bt) npc = btg;
        else         npc = m_pc + inc;

        if (npc >= 32'd512 || (npc % 4) != 0) begin
            @(negedge soc_clk);
            chk("flt_halted", 32'(bus.halted), 32'd1);
            chk("flt_flag",   32'(bus.pc_fault), 32'd1);
            chk("flt_pc",     bus.Cu_PC, m_pc);
            chk("flt_count",  bus.instr_count, m_count);
            chk("flt_phase",  32'(bus.phase), 32'd0);
            bus.run = 1'b1;
            for (int i = 0; i < 3; i++) begin
                step();
                chk("flt_nofetch", 32'(bus.memfetch_start), 32'd0);
            end
            stopped = 1'b1;
            return;
        end
        m_pc    = npc;
        m_count = m_count + 32'd1;
        if (!jv) m_lbs = bt;

        if (!run_after) begin
            @(negedge soc_clk);
            chk("idle_phase",   32'(bus.phase), 32'd0);
            chk("idle_pc",      bus.Cu_PC, m_pc);
            chk("idle_nofetch", 32'(bus.memfetch_start), 32'd0);
            step();
            chk("idle_hold", 32'(bus.memfetch_start), 32'd0);
            bus.run = 1'b1;
            step();
        end
    endtask

    function automatic logic [31:0] rand_target();
        int unsigned r;
        r = $urandom_range(0, 15);
        if (r == 0) return 32'h200 + (32'($urandom_range(0, 63)) << 2);
        if (r == 1) return (32'($urandom_range(0, 127)) << 2) | 32'd2;
        return 32'($urandom_range(0, 127)) << 2;
    endfunction

    initial begin
        bit st;
        int c0;
        int d0;
        int r0;
        reset   = 1'b0;
        bus.run = 1'b0;
        clear_inputs();

        // Three back-to-back instructions
        do_reset();
        fetch_q.delete();
        for (int i = 0; i < 3; i++) do_instr(0, 0, 0, 0, 0, 0, 32'd4, 1, 0, st);
        chk("b2b_fetch0", 32'(fetch_q[0]), 32'd1);
        chk("b2b_fetch1", 32'(fetch_q[1]), 32'd5);
        chk("b2b_fetch2", 32'(fetch_q[2]), 32'd9);
        chk("b2b_pc",     bus.Cu_PC, 32'd12);
        chk("b2b_count",  bus.instr_count, 32'd3);

        // Decoder stall of 3 cycles
        c0 = cyc; d0 = n_ds; r0 = n_cr;
        do_instr(3, 0, 0, 0, 0, 0, 32'd4, 1, 0, st);
        chk("stall_cycles", 32'(cyc - c0), 32'd7);
        chk("stall_dec1",   32'(n_ds - d0), 32'd1);
        chk("stall_rdy1",   32'(n_cr - r0), 32'd1);

        // Branch at PC=8, then jump+branch together at PC=8
        do_reset();
        do_instr(0, 0, 0, 0, 0, 0, 32'd4, 1, 0, st);
        do_instr(0, 0, 0, 0, 0, 0, 32'd4, 1, 0, st);
        do_instr(0, 1, 0, 0, 1, 32'h40, 32'd4, 1, 0, st);
        chk("br_pc",  bus.Cu_PC, 32'h40);
        chk("br_lbs", 32'(bus.last_branch_state), 32'd1);
        do_reset();
        do_instr(0, 0, 0, 0, 0, 0, 32'd4, 1, 0, st);
        do_instr(0, 0, 0, 0, 0, 0, 32'd4, 1, 0, st);
        do_instr(0, 0, 1, 32'h20, 1, 32'h40, 32'd4, 1, 0, st);
        chk("jmp_pc", bus.Cu_PC, 32'h20);

        // Jump to PC_LIMIT, then a misaligned jump
        do_reset();
        do_instr(0, 0, 1, 32'h200, 0, 0, 32'd4, 1, 0, st);
        chk("lim_fault", 32'(bus.pc_fault), 32'd1);
        chk("lim_pc",    bus.Cu_PC, 32'h0);
        do_reset();
        do_instr(0, 0, 0, 0, 0, 0, 32'd4, 1, 0, st);
        do_instr(1, 0, 1, 32'h102, 0, 0, 32'd4, 1, 0, st);
        chk("mis_fault", 32'(bus.pc_fault), 32'd1);
        chk("mis_pc",    bus.Cu_PC, 32'h4);

        // halt_req in ISSUE; then halt_req together with ALU_done
        do_reset();
        do_instr(0, 0, 0, 0, 0, 0, 32'd4, 1, 0, st);
        do_instr(0, 0, 0, 0, 0, 0, 32'd4, 1, 3, st);
        chk("hiss_count", bus.instr_count, 32'd1);
        do_reset();
        do_instr(0, 0, 0, 0, 0, 0, 32'd4, 1, 0, st);
        do_instr(1, 2, 0, 0, 1, 32'h80, 32'd4, 1, 4, st);
        chk("hcom_pc", bus.Cu_PC, 32'h4);

        // run dropped during DECODE, then resumed
        do_reset();
        do_instr(2, 1, 0, 0, 0, 0, 32'd4, 0, 0, st);
        do_instr(0, 0, 0, 0, 0, 0, 32'd4, 1, 0, st);
        chk("resume_pc", bus.Cu_PC, 32'h8);

        // Reset asserted in DECODE
        bus.IDU_ready = 1'b0;
        step();
        #2;
        reset = 1'b0;
        #1;
        chk("mid_pc",    bus.Cu_PC, 32'h0);
        chk("mid_phase", 32'(bus.phase), 32'd0);
        chk("mid_dec",   32'(bus.decode_start), 32'd0);
        chk("mid_count", bus.instr_count, 32'd0);
        step();
        step();
        chk("mid_nofetch", 32'(bus.memfetch_start), 32'd0);
        chk("mid_nordy",   32'(bus.CU_ready), 32'd0);

        // Randomized instruction stream against the reference model
        do_reset();
        for (int n = 0; n < 120; n++) begin
            int unsigned ir;
            logic [31:0] inc;
            ir = $urandom_range(0, 7);
            inc = (ir == 0) ? 32'd8 : (ir == 1) ? 32'hFFFF_FFFC : (ir == 2) ? 32'd2 : 32'd4;
            do_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     ($urandom_range(0, 7) == 0), rand_target(),
                     ($urandom_range(0, 3) == 0), rand_target(), inc,
                     ($urandom_range(0, 5) != 0),
                     ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 4)) : 0, st);
            if (st) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
